// File: rtl/disp_scan_ctrl.sv
// Scan controller for a windowed disparity engine: walks every pixel, issues the f/g RAM reads and sequences calc units and compare tree.
// Build option: define SCAN_SUBSAMPLE_EN to step px/py by 2 instead of 1.
module disp_scan_ctrl #(
    parameter int unsigned IMG_W   = 64,
    parameter int unsigned IMG_H   = 16,
    parameter int unsigned WIN     = 4,
    parameter int unsigned NDISP   = 16,
    parameter int unsigned CMP_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        hold,
    output logic [10:0] address_f,
    output logic [10:0] address_g,
    output logic        startsig,
    output logic        work,
    output logic        valid,
    output logic        finalstart,
    output logic        update,
    output logic [6:0]  out_x,
    output logic [3:0]  out_y,
    output logic        out_valid,
    output logic        busy,
    output logic        done
);

    localparam int unsigned X_W    = 7;
    localparam int unsigned Y_W    = 4;
    localparam int unsigned SPAN   = WIN + NDISP - 1;
    localparam int unsigned PX_MAX = IMG_W - SPAN;
    localparam int unsigned PY_MAX = IMG_H - WIN;
    localparam int unsigned C_W    = $clog2(SPAN + 1);
    localparam int unsigned WY_W   = $clog2(WIN + 1);
    localparam int unsigned LAT_W  = $clog2(CMP_LAT + 1);
`ifdef SCAN_SUBSAMPLE_EN
    localparam int unsigned STEP   = 2;
`else
    localparam int unsigned STEP   = 1;
`endif

    typedef enum logic [2:0] {
        IDLE, PRIME, ISSUE, DRAIN, WAIT_CMP, EMIT, NEXT
    } state_t;

    state_t            state;
    logic [X_W-1:0]    px;
    logic [Y_W-1:0]    py;
    logic [C_W-1:0]    c;
    logic [C_W-1:0]    c_nxt;
    logic [WY_W-1:0]   wy;
    logic [WY_W-1:0]   wy_nxt;
    logic [LAT_W-1:0]  lat;
    logic [10:0]       addr;
    logic [10:0]       addr_nxt;
    logic              last_read;
    logic              row_end;
    logic              last_pixel;

    // Next read position inside the window sweep and end-of-row/frame detection
    always_comb begin
        c_nxt  = c + C_W'(1);
        wy_nxt = wy;
        if (c == C_W'(SPAN - 1)) begin
            c_nxt  = '0;
            wy_nxt = wy + WY_W'(1);
        end
        last_read  = (c == C_W'(SPAN - 1)) && (wy == WY_W'(WIN - 1));
        addr_nxt   = {py + Y_W'(wy_nxt), px + X_W'(c_nxt)};
        row_end    = (32'(px) + STEP) > PX_MAX;
        last_pixel = row_end && ((32'(py) + STEP) > PY_MAX);
    end

    assign address_f = addr;
    assign address_g = addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            px         <= '0;
            py         <= '0;
            c          <= '0;
            wy         <= '0;
            lat        <= '0;
            addr       <= '0;
            startsig   <= 1'b0;
            work       <= 1'b0;
            valid      <= 1'b0;
            finalstart <= 1'b0;
            update     <= 1'b0;
            out_valid  <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            startsig   <= 1'b0;
            valid      <= 1'b0;
            finalstart <= 1'b0;
            update     <= 1'b0;
            out_valid  <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        px       <= '0;
                        py       <= '0;
                        busy     <= 1'b1;
                        startsig <= 1'b1;
                        state    <= PRIME;
                    end
                end
                PRIME: begin
                    c     <= '0;
                    wy    <= '0;
                    addr  <= {py, px};
                    work  <= 1'b1;
                    state <= ISSUE;
                end
                // A held cycle issues nothing; the address stays on the pending read
                ISSUE: begin
                    if (!hold) begin
                        valid <= 1'b1;
                        if (last_read) begin
                            state <= DRAIN;
                        end else begin
                            c    <= c_nxt;
                            wy   <= wy_nxt;
                            addr <= addr_nxt;
                        end
                    end
                end
                DRAIN: begin
                    work       <= 1'b0;
                    finalstart <= 1'b1;
                    lat        <= '0;
                    state      <= WAIT_CMP;
                end
                WAIT_CMP: begin
                    if (lat == LAT_W'(CMP_LAT - 1)) begin
                        update    <= 1'b1;
                        out_valid <= 1'b1;
                        out_x     <= px;
                        out_y     <= py;
                        state     <= EMIT;
                    end else begin
                        lat <= lat + LAT_W'(1);
                    end
                end
                EMIT: begin
                    if (last_pixel) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (row_end) begin
                        px <= '0;
                        py <= py + Y_W'(STEP);
                    end else begin
                        px <= px + X_W'(STEP);
                    end
                    startsig <= 1'b1;
                    state    <= PRIME;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Randomised-hold bench for disp_scan_ctrl against a cycle-event reference model of the scan schedule.
module tb_disp_scan_ctrl;

    localparam int unsigned IMG_W   = 64;
    localparam int unsigned IMG_H   = 16;
    localparam int unsigned WIN     = 4;
    localparam int unsigned NDISP   = 16;
    localparam int unsigned CMP_LAT = 4;
    localparam int unsigned SPAN    = WIN + NDISP - 1;
    localparam int unsigned READS   = WIN * SPAN;
    localparam int unsigned PX_MAX  = IMG_W - SPAN;
    localparam int unsigned PY_MAX  = IMG_H - WIN;
`ifdef SCAN_SUBSAMPLE_EN
    localparam int unsigned STEP    = 2;
`else
    localparam int unsigned STEP    = 1;
`endif
    localparam int unsigned NPX     = PX_MAX / STEP + 1;
    localparam int unsigned NPY     = PY_MAX / STEP + 1;
    localparam int          NEVER   = 1 << 30;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        hold;
    logic        hold_dir;
    logic        hold_rnd;
    logic        rand_en;
    logic [10:0] address_f;
    logic [10:0] address_g;
    logic        startsig;
    logic        work;
    logic        valid;
    logic        finalstart;
    logic        update;
    logic [6:0]  out_x;
    logic [3:0]  out_y;
    logic        out_valid;
    logic        busy;
    logic        done;

    disp_scan_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .NDISP(NDISP), .CMP_LAT(CMP_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .address_f(address_f), .address_g(address_g),
        .startsig(startsig), .work(work), .valid(valid),
        .finalstart(finalstart), .update(update),
        .out_x(out_x), .out_y(out_y), .out_valid(out_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign hold = rand_en ? hold_rnd : hold_dir;

    always @(posedge clk) begin
        #1;
        hold_rnd = ($urandom_range(0, 15) == 0);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: event times derived from the schedule rules
    int          cyc = 0;
    int          t_ss, t_prime, t_final, t_update, t_done;
    int          rem;
    bit          issue_prev;
    bit          busy_m;
    logic [10:0] addr_q[$];
    int          px_q[$];
    int          py_q[$];

    // Observations of the DUT used by directed checks
    int obs_ss_cyc = -1, obs_ss_n = 0, obs_upd_cyc = -1, obs_upd_n = 0;
    int obs_vcnt = 0, obs_first_v = -1, obs_last_v = -1;
    int obs_ov = 0, obs_done_n = 0, obs_last_x = -1, obs_last_y = -1;
    logic obs_busy_done = 1'bx;

    always @(negedge clk) begin
        bit e_ss, e_valid, e_final, e_upd, e_done, e_work, e_busy, issue_now;
        cyc++;
        if (rst) begin
            t_ss = NEVER; t_final = NEVER; t_update = NEVER; t_done = NEVER;
            t_prime = -1; rem = 0; issue_prev = 1'b0; busy_m = 1'b0;
            addr_q.delete(); px_q.delete(); py_q.delete();
        end else begin
            e_ss    = (cyc == t_ss);
            e_valid = issue_prev;
            e_final = (cyc == t_final);
            e_upd   = (cyc == t_update);
            e_done  = (cyc == t_done);
            e_work  = (t_prime >= 0) && (cyc > t_prime) && (cyc < t_final);
            e_busy  = busy_m;
            check("startsig", startsig, e_ss);
            check("valid", valid, e_valid);
            check("finalstart", finalstart, e_final);
            check("update", update, e_upd);
            check("out_valid", out_valid, e_upd);
            check("done", done, e_done);
            check("work", work, e_work);
            check("busy", busy, e_busy);

            issue_now = (rem > 0) && !hold;
            if (issue_now) begin
                check("rd_addr_f", address_f, addr_q[0]);
                check("rd_addr_g", address_g, addr_q[0]);
                check("rd_x_in_image", 32'(address_g[6:0] <= 7'(IMG_W - 1)), 1);
                void'(addr_q.pop_front());
                rem--;
                if (rem == 0) begin
                    t_final  = cyc + 2;
                    t_update = cyc + 2 + CMP_LAT;
                end
            end
            issue_prev = issue_now;

            if (e_ss) begin
                t_prime = cyc; t_final = NEVER; t_update = NEVER; t_ss = NEVER;
                rem = READS;
                for (int wy = 0; wy < WIN; wy++)
                    for (int c = 0; c < SPAN; c++)
                        addr_q.push_back({4'(py_q[0] + wy), 7'(px_q[0] + c)});
            end

            if (e_upd) begin
                check("out_x", out_x, px_q[0]);
                check("out_y", out_y, py_q[0]);
                void'(px_q.pop_front());
                void'(py_q.pop_front());
                if (px_q.size() == 0) begin
                    t_done = cyc + 1;
                    busy_m = 1'b0;
                end else begin
                    t_ss = cyc + 2;
                end
            end

            if (start && !e_busy) begin
                busy_m = 1'b1;
                t_ss   = cyc + 1;
                obs_ov = 0;
                for (int y = 0; y <= PY_MAX; y += STEP)
                    for (int x = 0; x <= PX_MAX; x += STEP) begin
                        px_q.push_back(x);
                        py_q.push_back(y);
                    end
            end
        end

        if (startsig) begin
            obs_ss_cyc = cyc; obs_ss_n++; obs_vcnt = 0; obs_first_v = -1;
        end
        if (valid) begin
            obs_vcnt++;
            if (obs_first_v < 0) obs_first_v = cyc;
            obs_last_v = cyc;
        end
        if (update) begin
            obs_upd_cyc = cyc; obs_upd_n++; obs_last_x = out_x; obs_last_y = out_y;
        end
        if (out_valid) obs_ov++;
        if (done) begin
            obs_done_n++;
            obs_busy_done = busy;
        end
    end

    task automatic check_all_zero();
        check("rst_address_f", address_f, 0);
        check("rst_address_g", address_g, 0);
        check("rst_startsig", startsig, 0);
        check("rst_work", work, 0);
        check("rst_valid", valid, 0);
        check("rst_finalstart", finalstart, 0);
        check("rst_update", update, 0);
        check("rst_out_x", out_x, 0);
        check("rst_out_y", out_y, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic pulse_start(input logic with_hold, output int start_cyc);
        @(posedge clk);
        #1;
        start = 1'b1;
        hold_dir = with_hold;
        start_cyc = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
        hold_dir = 1'b0;
    endtask

    task automatic wait_update(input int limit, input string tag);
        int n0;
        n0 = obs_upd_n;
        for (int i = 0; i < limit && obs_upd_n == n0; i++) @(posedge clk);
        check(tag, obs_upd_n, n0 + 1);
    endtask

    initial begin
        int s_cyc, d0, ov0;
        rst = 1'b1; start = 1'b0; hold_dir = 1'b0; rand_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all_zero();
        rst = 1'b0;

        // Pixel (0,0) with hold raised alongside start
        pulse_start(1'b1, s_cyc);
        wait_update(200, "p0_update_seen");
        check("p0_startsig_lat", obs_ss_cyc - s_cyc, 1);
        check("p0_valid_cnt", obs_vcnt, READS);
        check("p0_first_valid", obs_first_v - obs_ss_cyc, 2);
        check("p0_period", obs_upd_cyc - obs_ss_cyc, 1 + READS + 1 + CMP_LAT);
        check("p0_out_xy", {obs_last_y, obs_last_x}, 0);

        // Five-cycle hold starting at read 10 of pixel (0,0)
        apply_reset();
        pulse_start(1'b0, s_cyc);
        d0 = obs_ss_n;
        for (int i = 0; i < 20 && obs_ss_n == d0; i++) @(posedge clk);
        check("hold_startsig_seen", obs_ss_n, d0 + 1);
        repeat (10) @(posedge clk);
        #1 hold_dir = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_addr_frozen", address_f, 11'd10);
            @(posedge clk);
            #1;
        end
        hold_dir = 1'b0;
        wait_update(200, "hold_update_seen");
        check("hold_valid_cnt", obs_vcnt, READS);
        check("hold_valid_gaps", (obs_last_v - obs_first_v + 1) - obs_vcnt, 5);
        check("hold_period", obs_upd_cyc - obs_ss_cyc, 1 + READS + 1 + CMP_LAT + 5);

        // Abort mid-ISSUE of the pixel following (2,2)
        apply_reset();
        rand_en = 1'b1;
        pulse_start(1'b0, s_cyc);
        for (int i = 0; i < 30000 && !(obs_last_x == 2 && obs_last_y == 2); i++) @(posedge clk);
        check("abort_reached_2_2", {28'(obs_last_y), 4'(obs_last_x)}, {28'd2, 4'd2});
        repeat (25) @(posedge clk);
        check("abort_in_issue", work, 1);
        d0 = obs_done_n;
        ov0 = obs_ov;
        apply_reset();
        repeat (200) @(posedge clk);
        check("abort_no_done", obs_done_n, d0);
        check("abort_no_out_valid", obs_ov, ov0);
        check("abort_idle", busy, 0);

        // Full frame with random holds
        pulse_start(1'b0, s_cyc);
        d0 = obs_done_n;
        for (int i = 0; i < 90000 && obs_done_n == d0; i++) @(posedge clk);
        check("frame_done_once", obs_done_n, d0 + 1);
        check("frame_out_valid_cnt", obs_ov, NPX * NPY);
        check("frame_last_x", obs_last_x, (NPX - 1) * STEP);
        check("frame_last_y", obs_last_y, (NPY - 1) * STEP);
        check("frame_busy_at_done", obs_busy_done, 0);
        rand_en = 1'b0;
        repeat (3) @(posedge clk);
        check("frame_idle_after", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
